// File: rtl/nibble_ram_responder_if.sv
// Serial nibble RAM bus: initiator address/data nibbles, frame alignment and the
// host-side write port into the responder's word memory.
interface nibble_ram_responder_if #(
    parameter int RAM_PINS      = 4,
    parameter int WORD_BITS     = 16,
    parameter int MEM_ADDR_BITS = 6
);
    logic [RAM_PINS-1:0]      addr_bits;
    logic [RAM_PINS-1:0]      data_bits;
    logic                     sync;
    logic                     frame_start;
    logic                     wr_en;
    logic [MEM_ADDR_BITS-1:0] wr_addr;
    logic [WORD_BITS-1:0]     wr_data;

    modport master (
        output addr_bits, sync, wr_en, wr_addr, wr_data,
        input  data_bits, frame_start
    );

    modport slave (
        input  addr_bits, sync, wr_en, wr_addr, wr_data,
        output data_bits, frame_start
    );
endinterface

// File: rtl/nibble_ram_responder.sv
// Responds to a nibble-serial address frame with the addressed memory word,
// returned nibble-serially during the following frame (LS nibble first).
module nibble_ram_responder #(
    parameter int RAM_LOG2_CYCLES = 2,
    parameter int RAM_PINS        = 4,
    parameter int MEM_ADDR_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    nibble_ram_responder_if.slave bus
);
    localparam int RAM_CYCLES = 2 ** RAM_LOG2_CYCLES;
    localparam int W          = RAM_PINS * RAM_CYCLES;
    localparam int DEPTH      = 2 ** MEM_ADDR_BITS;
    localparam logic [RAM_LOG2_CYCLES-1:0] LAST_CYCLE = RAM_LOG2_CYCLES'(RAM_CYCLES - 1);

    logic [RAM_LOG2_CYCLES-1:0] cnt_q, cnt_d;
    logic [W-1:0]               addr_q, addr_d;
    logic [W-1:0]               word_q, word_d;
    logic [W-1:0]               full_addr;
    logic [MEM_ADDR_BITS-1:0]   rd_idx;
    logic                       unused_addr_hi;

    logic [W-1:0] mem [DEPTH];

    // The top nibble is taken straight from the bus so the read fires at the frame's last edge.
    always_comb begin
        full_addr                  = addr_q;
        full_addr[W-1 -: RAM_PINS] = bus.addr_bits;
    end

    assign rd_idx         = full_addr[MEM_ADDR_BITS-1:0];
    assign unused_addr_hi = ^full_addr;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = addr_q;
        addr_d[int'(cnt_q) * RAM_PINS +: RAM_PINS] = bus.addr_bits;
        word_d = word_q;
        if (cnt_q == LAST_CYCLE) begin
            word_d = mem[rd_idx];
        end
        if (bus.sync) begin
            cnt_d  = '0;
            addr_d = '0;
            word_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            addr_q <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            word_q <= word_d;
        end
    end

    // NOTE: the memory array has no reset; contents survive reset and sync, and the
    // frame-end read above sees the pre-write value when both hit the same word.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.data_bits   = word_q[int'(cnt_q) * RAM_PINS +: RAM_PINS];
    assign bus.frame_start = (cnt_q == '0);
endmodule

// File: tb/tb_nibble_ram_responder.sv
// Directed bench for nibble_ram_responder: frame latency, back-to-back frames,
// aliasing, read-before-write, mid-frame sync and mid-frame reset.
module tb_nibble_ram_responder;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    nibble_ram_responder_if #(.RAM_PINS(4), .WORD_BITS(16), .MEM_ADDR_BITS(6)) bus ();

    nibble_ram_responder #(
        .RAM_LOG2_CYCLES(2),
        .RAM_PINS       (4),
        .MEM_ADDR_BITS  (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full frame: drive addr nibbles, check frame_start and the previous frame's word.
    task automatic run_frame(input logic [15:0] addr, input logic [15:0] exp_word,
                             input string tag, input bit wr_last,
                             input logic [5:0] w_addr, input logic [15:0] w_data);
        for (int i = 0; i < 4; i++) begin
            bus.addr_bits = addr[i*4 +: 4];
            if (wr_last && i == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = w_addr;
                bus.wr_data = w_data;
            end
            check($sformatf("%s_fs%0d", tag, i), 32'(bus.frame_start), 32'(i == 0));
            check($sformatf("%s_d%0d", tag, i), 32'(bus.data_bits), 32'(exp_word[i*4 +: 4]));
            next_cycle();
            bus.wr_en = 1'b0;
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.addr_bits = '0;
        bus.sync      = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        // Preload memory while reset is held: writes must be honoured during reset.
        next_cycle();
        bus.wr_en = 1'b1;
        bus.wr_addr = 6'h05; bus.wr_data = 16'hBEEF; next_cycle();
        bus.wr_addr = 6'h01; bus.wr_data = 16'h1111; next_cycle();
        bus.wr_addr = 6'h02; bus.wr_data = 16'h2222; next_cycle();
        bus.wr_addr = 6'h03; bus.wr_data = 16'h3333; next_cycle();
        bus.wr_addr = 6'h07; bus.wr_data = 16'h1234; next_cycle();
        bus.wr_en = 1'b0;

        check("rst_fs", 32'(bus.frame_start), 32'h1);
        check("rst_data", 32'(bus.data_bits), 32'h0);
        reset = 1'b0;

        run_frame(16'h0005, 16'h0000, "f0",    1'b0, 6'h00, 16'h0000);
        run_frame(16'h0001, 16'hBEEF, "f1",    1'b0, 6'h00, 16'h0000);
        run_frame(16'h0002, 16'h1111, "f2",    1'b0, 6'h00, 16'h0000);
        run_frame(16'h0003, 16'h2222, "f3",    1'b0, 6'h00, 16'h0000);
        run_frame(16'hFFC5, 16'h3333, "f4",    1'b0, 6'h00, 16'h0000);
        run_frame(16'h0007, 16'hBEEF, "alias", 1'b1, 6'h07, 16'hABCD);
        run_frame(16'h0007, 16'h1234, "rbw",   1'b0, 6'h00, 16'h0000);
        run_frame(16'h0001, 16'hABCD, "newv",  1'b0, 6'h00, 16'h0000);

        // Partial frame addressing 0x0002, sync pulsed at c=2.
        bus.addr_bits = 4'h2;
        check("sy_d0", 32'(bus.data_bits), 32'h1);
        next_cycle();
        bus.addr_bits = 4'h0;
        check("sy_d1", 32'(bus.data_bits), 32'h1);
        next_cycle();
        bus.sync = 1'b1;
        check("sy_fs2", 32'(bus.frame_start), 32'h0);
        check("sy_d2", 32'(bus.data_bits), 32'h1);
        next_cycle();
        bus.sync = 1'b0;
        run_frame(16'h0003, 16'h0000, "post_sync", 1'b0, 6'h00, 16'h0000);
        run_frame(16'h0005, 16'h3333, "sync_ans",  1'b0, 6'h00, 16'h0000);

        // Frame addressing 0x0005 interrupted by reset at c=1.
        bus.addr_bits = 4'h5;
        check("rs_d0", 32'(bus.data_bits), 32'hF);
        next_cycle();
        reset = 1'b1;
        bus.addr_bits = 4'h0;
        next_cycle();
        reset = 1'b0;
        run_frame(16'h0005, 16'h0000, "post_rst", 1'b0, 6'h00, 16'h0000);
        run_frame(16'h0001, 16'hBEEF, "mem_kept", 1'b0, 6'h00, 16'h0000);
        run_frame(16'h0000, 16'h1111, "tail",     1'b0, 6'h00, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_ram_responder.md
NIBBLE_RAM_RESPONDER -- requirements
Module: nibble_ram_responder

Interface
REQ-001 Parameter RAM_LOG2_CYCLES, default 2: log2 of the number of nibble cycles per frame (RAM_CYCLES = 2**RAM_LOG2_CYCLES).
REQ-002 Parameter RAM_PINS, default 4: width of the serial address and data buses; word width W = RAM_PINS*RAM_CYCLES (16 at defaults).
REQ-003 Parameter MEM_ADDR_BITS, default 6: log2 of memory depth in W-bit words.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 addr_bits  input  RAM_PINS  serial address nibble from the initiator, least-significant nibble first.
REQ-007 data_bits  output  RAM_PINS  serial read-data nibble to the initiator, least-significant nibble first.
REQ-008 sync  input  1  frame realignment request.
REQ-009 wr_en  input  1  host memory write strobe.
REQ-010 wr_addr  input  MEM_ADDR_BITS  host write word address.
REQ-011 wr_data  input  W  host write word.
REQ-012 frame_start  output  1  high while the cycle counter is 0.

Function
REQ-013 The block SHALL hold a RAM_LOG2_CYCLES-bit cycle counter c that increments by 1 every cycle and wraps from RAM_CYCLES-1 to 0.
REQ-014 In a cycle with counter c, the block SHALL capture addr_bits into address bits [c*RAM_PINS +: RAM_PINS] of a capture register at the posedge ending that cycle.
REQ-015 At the posedge ending a cycle with c = RAM_CYCLES-1, the block SHALL read memory at the full address (current addr_bits as the top nibble, captured lower nibbles), using only its low MEM_ADDR_BITS bits, and load the result into the output word register.
REQ-016 Address bits at or above MEM_ADDR_BITS SHALL be ignored (addresses alias modulo 2**MEM_ADDR_BITS).
REQ-017 data_bits SHALL be combinational: output word register bits [c*RAM_PINS +: RAM_PINS] for the current c.
REQ-018 Latency: the address delivered in frame k SHALL have its data on data_bits throughout frame k+1 (nibble 0 appears the cycle after the last address nibble).
REQ-019 When wr_en = 1, the block SHALL write wr_data to memory word wr_addr at the posedge, regardless of counter value.
REQ-020 A write and a frame-end read of the same word at the same posedge SHALL return the pre-write contents (read-before-write); the new value SHALL be visible to the next frame's read.
REQ-021 When sync = 1 and reset = 0 at a posedge, the block SHALL set c to 0, clear the capture register and output word register, and skip the memory read that cycle; memory writes SHALL still occur.
REQ-022 frame_start SHALL equal (c == 0).
REQ-023 Memory contents SHALL be undefined until written and SHALL NOT be altered by reset or sync.

Reset
REQ-024 With reset = 1 at a posedge, the block SHALL set c to 0 and clear the capture and output word registers, so data_bits = 0 and frame_start = 1 in the following cycle.
REQ-025 reset SHALL take priority over sync; wr_en SHALL be honoured during reset.
REQ-026 Reset asserted mid-frame SHALL discard the partial address; the first frame after reset SHALL return data_bits = 0 for all RAM_CYCLES nibbles.

Verification
REQ-027 Write mem[0x05]=0xBEEF, release reset, drive addr nibbles 5,0,0,0 in frame 0 -> data_bits 0xF,0xE,0xE,0xB in frame 1 cycles 0..3; frame 0 data_bits all 0.
REQ-028 Back-to-back frames with addresses 0x0001, 0x0002, 0x0003 (mem[i] = 0x1111*i) -> frames 1..3 return 0x1111, 0x2222, 0x3333 nibble-serially, no gaps.
REQ-029 Address 0xFFC5 with mem[0x05]=0xBEEF -> returns 0xBEEF (aliasing).
REQ-030 mem[0x07]=0x1234; wr_en writing 0xABCD to 0x07 at the frame-end posedge of a frame reading 0x0007 -> next frame returns 0x1234; repeat read -> 0xABCD.
REQ-031 Pulse sync at c=2 -> next cycle frame_start=1, data_bits=0; address nibbles sent from that cycle are answered in the following frame.
REQ-032 Assert reset at c=1 of a frame addressing 0x0005 -> first post-reset frame data_bits all 0, frame_start=1 in first post-reset cycle, mem[0x05] still 0xBEEF.
